// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ArbAddrBus = 32;
  localparam int unsigned DataBus    = 32;

  typedef enum logic [1:0] {
    RespNone = 2'b00,
    RespIF   = 2'b01,
    RespD    = 2'b10
  } resp_tag_e;

  // Stores return nothing, so only reads leave a tag behind.
  function automatic resp_tag_e next_tag(
    input logic ig,
    input logic dg,
    input logic we
  );
    if (ig) begin
      return RespIF;
    end else if (dg && !we) begin
      return RespD;
    end else begin
      return RespNone;
    end
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive denied fetch cycles and forces a fetch win at MAX_WAIT.
module mem_arb_starve_cnt #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || !if_req || if_gnt) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign force_if = if_req
                 && (wait_cnt == CW'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for the single-port data RAM.
// Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ArbAddrBus,
  parameter int unsigned DATA_W   = DataBus,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic      force_if;
  resp_tag_e resp_tag;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_gnt   (if_gnt),
    .force_if (force_if)
  );
`else
  logic [$clog2(MAX_WAIT+1)-1:0] unused_wait;
  assign unused_wait = '0;
  assign force_if    = 1'b0;
`endif

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst) begin
      if_gnt = 1'b0;
    end else if (force_if) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_tag <= RespNone;
    end else begin
      resp_tag <= next_tag(if_gnt, d_gnt, d_we);
    end
  end

  // Reset in the response cycle cancels the pending read.
  always_comb begin
    if_rvalid = !rst && (resp_tag == RespIF);
    d_rvalid  = !rst && (resp_tag == RespD);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a queue-free
// cycle model and its own RAM image.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5000000 ^ (i * 32'h01010101);
  endfunction

  // RAM seen by the DUT: synchronous read, junk when not reading.
  logic [31:0] env_ram [256];
  bit          env_wr  [256];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      env_ram[mem_addr[9:2]] <= mem_wdata;
      env_wr[mem_addr[9:2]]  <= 1'b1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= env_wr[mem_addr[9:2]]
                 ? env_ram[mem_addr[9:2]]
                 : init_word(int'(mem_addr[9:2]));
    end else begin
      mem_rdata <= $urandom;
    end
  end

  int errors = 0;
  int checks = 0;

  // Model state: owner of the outstanding read, read word, denied streak.
  int          m_tag;
  logic [31:0] m_rd;
  int          m_wait;
  logic [31:0] m_ram [256];

  logic        o_ig, o_dg, o_iv, o_dv;
  logic [31:0] o_maddr, o_ird, o_drd;
  bit          last_ig, last_dg;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r,
                      input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw,
                      input logic [31:0] da,
                      input logic [31:0] dd);
    bit frc, e_ig, e_dg, e_iv, e_dv;
    logic [31:0] e_addr, e_wd;
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    @(negedge clk);
    frc  = GUARD && ir && (m_wait == MAX_WAIT);
    e_dg = !r && dr && !frc;
    e_ig = !r && ir && !e_dg;
    e_addr = e_dg ? da : (e_ig ? ia : 32'h0);
    e_wd   = e_dg ? dd : 32'h0;
    e_iv = !r && (m_tag == 1);
    e_dv = !r && (m_tag == 2);
    chk("if_gnt", if_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    chk("mem_en", mem_en, e_ig | e_dg);
    chk("mem_we", mem_we, e_dg & dw);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_rvalid", if_rvalid, e_iv);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("if_rdata", if_rdata, e_iv ? m_rd : 32'h0);
    chk("d_rdata", d_rdata, e_dv ? m_rd : 32'h0);
    o_ig = if_gnt; o_dg = d_gnt;
    o_iv = if_rvalid; o_dv = d_rvalid;
    o_maddr = mem_addr; o_ird = if_rdata; o_drd = d_rdata;
    @(posedge clk);
    last_ig = e_ig; last_dg = e_dg;
    if (r) begin
      m_tag = 0; m_wait = 0;
    end else begin
      m_tag = e_ig ? 1 : ((e_dg && !dw) ? 2 : 0);
      if (e_ig) m_rd = m_ram[ia[9:2]];
      else if (e_dg && !dw) m_rd = m_ram[da[9:2]];
      if (e_dg && dw) m_ram[da[9:2]] = dd;
      m_wait = (ir && !e_ig) ? m_wait + 1 : 0;
    end
    #1;
  endtask

  task automatic idle(input bit r);
    step(r, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    bit p_if, p_d, dw_r;
    logic [31:0] ia_r, da_r, dd_r;
    int first, n_ig, fdg, after;
    m_tag = 0; m_wait = 0; m_rd = '0;
    for (int i = 0; i < 256; i++) m_ram[i] = init_word(i);

    step(1, 1, 32'h10, 1, 0, 32'h20, 32'h0);
    chk("rst_gnt", {o_ig, o_dg}, 2'b00);
    step(1, 1, 32'h10, 1, 0, 32'h20, 32'h0);
    chk("rst_rvalid", {o_iv, o_dv}, 2'b00);

    step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    chk("fetch_gnt", o_ig, 1'b1);
    chk("fetch_addr", o_maddr, 32'h10);
    idle(0);
    chk("fetch_rv", {o_iv, o_dv}, 2'b10);
    chk("fetch_data", o_ird, 32'hDEADBEEF);

    step(0, 1, 32'h24, 1, 0, 32'h20, 32'h0);
    chk("tie_gnt", {o_ig, o_dg}, 2'b01);
    step(0, 1, 32'h24, 0, 0, 32'h0, 32'h0);
    chk("tie_if_next", {o_ig, o_dv}, 2'b11);
    idle(0);
    chk("tie_if_rv", o_iv, 1'b1);

    step(0, 0, 32'h0, 1, 1, 32'h30, 32'h12345678);
    step(0, 0, 32'h0, 1, 0, 32'h30, 32'h0);
    chk("store_no_rv", {o_iv, o_dv}, 2'b00);
    idle(0);
    chk("load_data", o_drd, 32'h12345678);

    first = 0; n_ig = 0; fdg = 1; after = 1;
    for (int c = 1; c <= 20; c++) begin
      step(0, 1, 32'h44, 1, 0, 32'h40, 32'h0);
      if (o_ig) n_ig++;
      if (o_ig && first == 0) begin
        first = c; fdg = o_dg;
      end
      if (first != 0 && c == first + 1) after = o_ig;
    end
    if (GUARD) begin
      chk("starve_first", first, MAX_WAIT + 1);
      chk("starve_dgnt", fdg, 0);
      chk("starve_restart", after, 0);
      chk("starve_count", n_ig, 20 / (MAX_WAIT + 1));
    end else begin
      chk("starve_none", n_ig, 0);
    end
    idle(0);

    step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    idle(1);
    chk("rst_mid_n1", o_iv, 1'b0);
    idle(0);
    chk("rst_mid_n2", o_iv, 1'b0);

    p_if = 0; p_d = 0; dw_r = 0;
    ia_r = '0; da_r = '0; dd_r = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p_if && $urandom_range(0, 2) != 0) begin
        p_if = 1;
        ia_r = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
      end
      if (!p_d && $urandom_range(0, 1) != 0) begin
        p_d  = 1;
        dw_r = $urandom_range(0, 1) != 0;
        da_r = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
        dd_r = $urandom;
      end
      step($urandom_range(0, 49) == 0,
           p_if, p_if ? ia_r : 32'h0,
           p_d, p_d & dw_r, p_d ? da_r : 32'h0,
           p_d ? dd_r : 32'h0);
      if (last_ig) p_if = 0;
      if (last_dg) p_d = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port data RAM between the CPU instruction-fetch path and the load/store path. It sits between `top` and `RAM` in the system. It grants at most one access per cycle and steers the RAM read data back to the requester that issued the read, one cycle later. Fetch requests lose ties to data requests. A compile-time starvation guard bounds how long fetch can wait.

## Interface
Parameters:
- ADDR_W, 32, address width of both requesters and the RAM port
- DATA_W, 32, data width (matches `DataBus`/`InstBus`)
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win (≥1; used only with guard enabled)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch access request (read only)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  load/store accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read strobe

## Operation
- **Grant.** Grant is combinational in cycle N. An access completes at the rising edge ending cycle N when its gnt=1. A requester holds req and its address/data until gnt.
- **Priority.**
  - d_req wins over if_req, unless the starvation guard fires.
  - At most one of if_gnt/d_gnt is high in any cycle.
- **RAM port.** mem_en = if_gnt | d_gnt. mem_we = d_gnt & d_we. mem_addr and mem_wdata are muxed from the granted requester. With no grant, mem_addr and mem_wdata are 0.
- **Response tag register** `resp_tag` (NONE/IF/D):
  - set to IF on a fetch grant;
  - set to D on a load grant;
  - set to NONE on a store grant, no grant, or rst.
- **Response outputs.**
  - if_rvalid = (resp_tag==IF); d_rvalid = (resp_tag==D).
  - x_rdata = mem_rdata when x_rvalid, else 0.
- **Back-to-back.** Grants are accepted back-to-back every cycle. The response of cycle N and the grant of cycle N+1 coexist without conflict.
- **Reset.**
  - While rst=1: if_gnt=d_gnt=0, mem_en=mem_we=0, mem_addr=mem_wdata=0. resp_tag and wait_cnt clear at the edge.
  - After the first clock with rst=1: all outputs read 0.
  - rst asserted in the cycle after a read grant cancels that response: rvalid=0.

## Timing
- Grant latency: 0 cycles (same-cycle req→gnt, combinational path req→gnt→mem_*).
- Read data latency: exactly 1 cycle after grant. rvalid is a registered tag; rdata passes through combinationally from mem_rdata.
- Store: completes at the grant edge; no rvalid.
- Fetch throughput under continuous d_req:
  - guard enabled: 1 grant per MAX_WAIT+1 cycles;
  - guard disabled: 0.

## Configuration
- Macro `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - wait_cnt (width $clog2(MAX_WAIT+1)) increments each cycle with if_req & ~if_gnt.
  - It clears on if_gnt, on ~if_req, or on rst.
  - When wait_cnt==MAX_WAIT and if_req=1, fetch wins that cycle regardless of d_req, and d_gnt=0.
- **Undefined:** no counter; pure fixed data priority, and fetch may starve indefinitely.

## Structure
- Shared constants go in `defines.v`: `RespNone 2'b00`, `RespIF 2'b01`, `RespD 2'b10`, and `ArbAddrBus`/`DataBus` widths.
- One sub-module, `mem_arb_starve_cnt` (counter plus force output). It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- **Reset.** rst=1 for 2 cycles with if_req=d_req=1 → all gnt/mem_en/rvalid=0.
- **Single fetch.** After release, if_req=1 alone with if_addr=0x10, RAM[0x10]=0xDEADBEEF → if_gnt=1 and mem_addr=0x10 in cycle N; in N+1 if_rvalid=1 and if_rdata=0xDEADBEEF, with d_rvalid=0.
- **Tie.** Simultaneous d_req load at 0x20 and if_req at 0x24 → d_gnt first, d_rvalid next cycle. if_gnt follows in the next cycle once d_req drops, and if_rvalid comes one cycle after that.
- **Store then load.** Store d_addr=0x30, d_wdata=0x12345678, then load 0x30 → no rvalid after the store; d_rdata=0x12345678 on the following load response.
- **Starvation.** Guard enabled, MAX_WAIT=4, d_req held high with if_req high → if_gnt=1 on the 5th cycle, d_gnt=0 that cycle, wait_cnt=0 after. Guard disabled → if_gnt never asserts over 20 cycles.
- **Reset mid-read.** Fetch granted in cycle N, rst=1 in N+1 → if_rvalid=0 in N+1 and N+2.
